gpio_apb_irq: RTL and testbench
===============================

// Module: gpio_apb_irq
// PURPOSE
//  Parametrised APB GPIO for the SoC peripheral bus: N pins with output, direction and input registers.
//  Adds what the first-generation GPIO lacked:
//   - atomic set/clear/toggle of outputs
//   - per-pin input synchroniser and optional debounce
//   - per-pin level/edge interrupts with polarity and both-edge mode, plus W1C status.
//  Single APB slave, zero wait state; one combined interrupt line to the interrupt controller.
// PARAMETERS
//  AW        32  APB address width; only paddr_i[5:2] is decoded
//  DW        32  APB data width
//  N         32  number of GPIO pins, 1..DW; register bits [DW-1:N] read 0, ignore writes
//  SYNC_STG  2   input synchroniser flops, >=2
//  DB_W      8   debounce threshold/counter width
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous reset, active-low
//  psel_i      in   1   APB select
//  penable_i   in   1   APB enable
//  pwrite_i    in   1   1=write
//  paddr_i     in   AW  byte address
//  pwdata_i    in   DW  write data
//  pstrb_i     in   4   byte-lane strobes
//  pprot_i     in   3   protection; ignored
//  prdata_o    out  DW  read data
//  pslverr_o   out  1   error response
//  pready_o    out  1   ready, tied 1
//  gpio_o      out  N   output data
//  gpio_i      in   N   pad input, asynchronous
//  gpio_en_o   out  N   output enable, 1=drive
//  gpio_int_o  out  1   combined interrupt, active-high
// BEHAVIOUR
//  Reset: all registers, sync/debounce state, edge history and status go to 0.
//   gpio_o=0, gpio_en_o=0, gpio_int_o=0, prdata_o=0, pslverr_o=0, pready_o=1.
//  APB access phase is psel_i&penable_i.
//   - Writes commit on the clk edge that ends the access phase.
//   - pstrb_i masks bytes on RW registers; W1S/W1C/W1T registers also honour strobes.
//   - prdata_o is the register value during a read access phase, else 0.
//   - Unmapped offset: pslverr_o=1 in the access phase, write dropped, prdata_o=0.
//  Register map (offset: name, access):
//   00 OUT RW; 04 OUT_SET W1S; 08 OUT_CLR W1C; 0C OUT_TGL W1T (SET/CLR/TGL read 0)
//   10 DIR RW; 14 IN RO (post-sync/debounce); 18 INT_EN RW; 1C INT_TYPE RW (1=edge, 0=level)
//   20 INT_POL RW (1=high/rising, 0=low/falling); 24 INT_BOTH RW (edge mode: both edges)
//   28 INT_STAT RW1C; 2C DB_CNT RW [DB_W-1:0]; 30 DB_EN RW
//  Input path: gpio_i -> SYNC_STG flops -> debounce -> IN.
//   - Debounce bypass when DB_EN[i]=0 or DB_CNT=0.
//   - Debounce: per-pin counter increments while sync != IN[i], clears when equal.
//   - IN[i] flips on the cycle the counter reaches DB_CNT; the counter saturates, never wraps.
//  Events: edge detect compares IN with its 1-cycle-delayed copy.
//   - Level mode: event every cycle the level matches INT_POL.
//   - STAT[i] sets on the edge after an event only if INT_EN[i]=1.
//   - Set beats a same-cycle W1C, so a W1C on an active level re-sets.
//   - Clearing INT_EN[i] does not clear STAT[i].
//  gpio_int_o = |STAT, driven from flops only.
//  Latency (SYNC_STG=2, bypass): gpio_i change sampled at edge k.
//   IN visible after edge k+1, STAT and gpio_int_o high after edge k+2.
//  Mid-op reset: everything clears asynchronously; a pending debounce count is discarded.
// TESTING
//  1. OUT=0x0000_00F0; SET 0x1; CLR 0x10; TGL 0x300 -> OUT=0x0000_03E1; SET/CLR/TGL read 0.
//  2. pstrb_i=4'b0010 write 0xAABBCCDD to DIR from 0 -> DIR=0x0000_CC00.
//     Read 0x3C -> pslverr_o=1, prdata_o=0.
//  3. INT_EN[3]=1, TYPE=1, POL=1; gpio_i[3] 0->1 -> STAT=0x8 two edges after sampling, gpio_int_o=1.
//     W1C 0x8 -> gpio_int_o=0; 1->0 on the pin -> no event.
//  4. INT_BOTH[5]=1: pulse gpio_i[5] -> STAT[5] set on both edges.
//     A rise coinciding with the W1C write cycle leaves STAT[5]=1.
//  5. Level-low on pin 0, held 0, W1C each cycle -> STAT[0] stays 1.
//     Pin to 1, then W1C -> STAT[0]=0.
//  6. DB_EN[2]=1, DB_CNT=4:
//     - 3-cycle glitch on pin 2 -> IN[2] unchanged, no interrupt.
//     - 6-cycle pulse -> IN[2] toggles.
//     - rst_n low mid-count -> IN=0, all outputs at reset values.

Source files
------------

// File: rtl/gpio_apb_irq.sv
// APB GPIO with atomic set/clear/toggle, synchronised and optionally debounced inputs,
// and per-pin level/edge interrupts collected into one W1C status register.
module gpio_apb_irq #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int N        = 32,
    parameter int SYNC_STG = 2,
    parameter int DB_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          psel_i,
    input  logic          penable_i,
    input  logic          pwrite_i,
    input  logic [AW-1:0] paddr_i,
    input  logic [DW-1:0] pwdata_i,
    input  logic [3:0]    pstrb_i,
    input  logic [2:0]    pprot_i,
    output logic [DW-1:0] prdata_o,
    output logic          pslverr_o,
    output logic          pready_o,
    output logic [N-1:0]  gpio_o,
    input  logic [N-1:0]  gpio_i,
    output logic [N-1:0]  gpio_en_o,
    output logic          gpio_int_o
);
    localparam logic [3:0] A_OUT  = 4'h0, A_SET  = 4'h1, A_CLR  = 4'h2, A_TGL  = 4'h3;
    localparam logic [3:0] A_DIR  = 4'h4, A_IN   = 4'h5, A_IEN  = 4'h6, A_TYPE = 4'h7;
    localparam logic [3:0] A_POL  = 4'h8, A_BOTH = 4'h9, A_STAT = 4'hA, A_DBC  = 4'hB;
    localparam logic [3:0] A_DBEN = 4'hC;
    localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

    logic [N-1:0]    out_q, dir_q, ien_q, type_q, pol_q, both_q, stat_q, dben_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [N-1:0]    sync_q [SYNC_STG];
    logic [DB_W-1:0] cnt_q [N];
    logic [DB_W-1:0] cnt_d [N];
    logic [N-1:0]    db_q, db_d, in_val, in_d_q, bypass;
    logic [N-1:0]    rise, fall, edge_ev, level_ev, set_ev, w1c, stat_d;
    logic            int_q;

    logic            access, wr, mapped;
    logic [3:0]      idx;
    logic [DW-1:0]   bmask, rdata;
    logic [N-1:0]    wmask, wbits;

    assign access = psel_i & penable_i;
    assign idx    = paddr_i[5:2];
    assign mapped = (idx <= A_DBEN);
    assign wr     = access & pwrite_i & mapped;

    for (genvar b = 0; b < DW; b++) begin : g_bmask
        assign bmask[b] = pstrb_i[(b / 8) % 4];
    end
    assign wmask = bmask[N-1:0];
    assign wbits = pwdata_i[N-1:0] & wmask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            type_q   <= '0;
            pol_q    <= '0;
            both_q   <= '0;
            dben_q   <= '0;
            db_cnt_q <= '0;
        end else if (wr) begin
            case (idx)
                A_OUT:   out_q  <= (out_q & ~wmask) | wbits;
                A_SET:   out_q  <= out_q | wbits;
                A_CLR:   out_q  <= out_q & ~wbits;
                A_TGL:   out_q  <= out_q ^ wbits;
                A_DIR:   dir_q  <= (dir_q & ~wmask) | wbits;
                A_IEN:   ien_q  <= (ien_q & ~wmask) | wbits;
                A_TYPE:  type_q <= (type_q & ~wmask) | wbits;
                A_POL:   pol_q  <= (pol_q & ~wmask) | wbits;
                A_BOTH:  both_q <= (both_q & ~wmask) | wbits;
                A_DBC:   db_cnt_q <= (db_cnt_q & ~bmask[DB_W-1:0])
                                   | (pwdata_i[DB_W-1:0] & bmask[DB_W-1:0]);
                A_DBEN:  dben_q <= (dben_q & ~wmask) | wbits;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STG; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int s = 1; s < SYNC_STG; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // In bypass the debounce state shadows the synchroniser so enabling debounce starts clean.
    assign bypass = ~dben_q | {N{db_cnt_q == '0}};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bypass[i]) begin
                db_d[i]  = sync_q[SYNC_STG-1][i];
                cnt_d[i] = '0;
            end else if (sync_q[SYNC_STG-1][i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= db_cnt_q - DB_ONE) begin
                db_d[i]  = sync_q[SYNC_STG-1][i];
                cnt_d[i] = '0;
            end else if (cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + DB_ONE;
            end
        end
    end

    assign in_val = (bypass & sync_q[SYNC_STG-1]) | (~bypass & db_q);

    assign rise     = in_val & ~in_d_q;
    assign fall     = ~in_val & in_d_q;
    assign edge_ev  = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
    assign level_ev = (pol_q & in_val) | (~pol_q & ~in_val);
    assign set_ev   = ien_q & ((type_q & edge_ev) | (~type_q & level_ev));
    assign w1c      = (wr && idx == A_STAT) ? wbits : '0;
    // A new event wins over a same-cycle clear, so an active level re-asserts immediately.
    assign stat_d   = (stat_q & ~w1c) | set_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            db_q   <= '0;
            in_d_q <= '0;
            stat_q <= '0;
            int_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            db_q   <= db_d;
            in_d_q <= in_val;
            stat_q <= stat_d;
            int_q  <= |stat_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            A_OUT:   rdata[N-1:0]    = out_q;
            A_DIR:   rdata[N-1:0]    = dir_q;
            A_IN:    rdata[N-1:0]    = in_val;
            A_IEN:   rdata[N-1:0]    = ien_q;
            A_TYPE:  rdata[N-1:0]    = type_q;
            A_POL:   rdata[N-1:0]    = pol_q;
            A_BOTH:  rdata[N-1:0]    = both_q;
            A_STAT:  rdata[N-1:0]    = stat_q;
            A_DBC:   rdata[DB_W-1:0] = db_cnt_q;
            A_DBEN:  rdata[N-1:0]    = dben_q;
            default: rdata = '0;
        endcase
    end

    assign prdata_o   = (access & ~pwrite_i & mapped) ? rdata : '0;
    assign pslverr_o  = access & ~mapped;
    assign pready_o   = 1'b1;
    assign gpio_o     = out_q;
    assign gpio_en_o  = dir_q;
    assign gpio_int_o = int_q;

    logic unused_ok;
    assign unused_ok = ^{pprot_i, paddr_i, pwdata_i, bmask};
endmodule

// File: tb/tb_gpio_apb_irq.sv
// Directed bench for gpio_apb_irq: register ops, strobes, error response,
// interrupt modes, debounce and asynchronous reset.
module tb_gpio_apb_irq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] prdata;
    logic        pslverr, pready;
    logic [31:0] gpio_out, gpio_in = '0, gpio_en;
    logic        gpio_int;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic        err;

    gpio_apb_irq dut (
        .clk(clk), .rst_n(rst_n),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
        .prdata_o(prdata), .pslverr_o(pslverr), .pready_o(pready),
        .gpio_o(gpio_out), .gpio_i(gpio_in), .gpio_en_o(gpio_en), .gpio_int_o(gpio_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        // Reset values
        wait_cyc(3);
        check("rst_gpio_o", gpio_out, 32'h0);
        check("rst_gpio_en", gpio_en, 32'h0);
        check("rst_int", {31'h0, gpio_int}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_pready", {31'h0, pready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);

        // Atomic output operations
        apb_write(32'h00, 32'h0000_00F0, 4'hF);
        apb_write(32'h04, 32'h0000_0001, 4'hF);
        apb_write(32'h08, 32'h0000_0010, 4'hF);
        apb_write(32'h0C, 32'h0000_0300, 4'hF);
        check("out_pins", gpio_out, 32'h0000_03E1);
        apb_read(32'h00, rd, err);
        check("out_read", rd, 32'h0000_03E1);
        apb_read(32'h04, rd, err);
        check("set_read0", rd, 32'h0);
        apb_read(32'h08, rd, err);
        check("clr_read0", rd, 32'h0);
        apb_read(32'h0C, rd, err);
        check("tgl_read0", rd, 32'h0);

        // Byte strobes and unmapped offset
        apb_write(32'h10, 32'hAABB_CCDD, 4'b0010);
        apb_read(32'h10, rd, err);
        check("dir_strb", rd, 32'h0000_CC00);
        check("dir_pins", gpio_en, 32'h0000_CC00);
        apb_read(32'h3C, rd, err);
        check("unmapped_err", {31'h0, err}, 32'h1);
        check("unmapped_rd", rd, 32'h0);
        apb_read(32'h00, rd, err);
        check("mapped_noerr", {31'h0, err}, 32'h0);

        // Rising-edge interrupt on pin 3
        apb_write(32'h1C, 32'h0000_0008, 4'hF);
        apb_write(32'h20, 32'h0000_0008, 4'hF);
        apb_write(32'h18, 32'h0000_0008, 4'hF);
        wait_cyc(2);
        check("edge_idle", {31'h0, gpio_int}, 32'h0);
        gpio_in[3] = 1'b1;
        wait_cyc(1);
        check("edge_lat_k", {31'h0, gpio_int}, 32'h0);
        wait_cyc(1);
        check("edge_lat_k1", {31'h0, gpio_int}, 32'h0);
        wait_cyc(1);
        check("edge_lat_k2", {31'h0, gpio_int}, 32'h1);
        apb_read(32'h28, rd, err);
        check("edge_stat", rd, 32'h0000_0008);
        apb_read(32'h14, rd, err);
        check("in_pin3", rd, 32'h0000_0008);
        apb_write(32'h28, 32'h0000_0008, 4'hF);
        check("edge_w1c", {31'h0, gpio_int}, 32'h0);
        gpio_in[3] = 1'b0;
        wait_cyc(4);
        check("edge_fall_none", {31'h0, gpio_int}, 32'h0);
        apb_read(32'h28, rd, err);
        check("edge_fall_stat", rd, 32'h0);

        // Both-edge mode on pin 5
        apb_write(32'h1C, 32'h0000_0028, 4'hF);
        apb_write(32'h24, 32'h0000_0020, 4'hF);
        apb_write(32'h18, 32'h0000_0028, 4'hF);
        gpio_in[5] = 1'b1;
        wait_cyc(3);
        apb_read(32'h28, rd, err);
        check("both_rise", rd, 32'h0000_0020);
        apb_write(32'h28, 32'h0000_0020, 4'hF);
        check("both_rise_w1c", {31'h0, gpio_int}, 32'h0);
        gpio_in[5] = 1'b0;
        wait_cyc(3);
        apb_read(32'h28, rd, err);
        check("both_fall", rd, 32'h0000_0020);
        apb_write(32'h28, 32'h0000_0020, 4'hF);
        check("both_fall_w1c", {31'h0, gpio_int}, 32'h0);
        gpio_in[5] = 1'b1;
        apb_write(32'h28, 32'h0000_0020, 4'hF);
        check("set_beats_w1c_int", {31'h0, gpio_int}, 32'h1);
        apb_read(32'h28, rd, err);
        check("set_beats_w1c", rd, 32'h0000_0020);
        gpio_in[5] = 1'b0;
        wait_cyc(3);
        apb_write(32'h28, 32'h0000_0020, 4'hF);
        check("both_cleanup", {31'h0, gpio_int}, 32'h0);

        // Level-low on pin 0
        apb_write(32'h18, 32'h0000_0001, 4'hF);
        wait_cyc(1);
        check("level_set", {31'h0, gpio_int}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            apb_write(32'h28, 32'h0000_0001, 4'hF);
            check("level_w1c_reset", {31'h0, gpio_int}, 32'h1);
        end
        gpio_in[0] = 1'b1;
        wait_cyc(4);
        apb_write(32'h28, 32'h0000_0001, 4'hF);
        check("level_inactive_w1c", {31'h0, gpio_int}, 32'h0);
        apb_read(32'h28, rd, err);
        check("level_stat_clear", rd, 32'h0);
        apb_write(32'h18, 32'h0000_0000, 4'hF);
        gpio_in[0] = 1'b0;
        wait_cyc(4);

        // Debounce on pin 2, threshold 4
        apb_write(32'h2C, 32'h1234_5604, 4'hF);
        apb_read(32'h2C, rd, err);
        check("dbcnt_width", rd, 32'h0000_0004);
        apb_write(32'h30, 32'h0000_0004, 4'hF);
        gpio_in[2] = 1'b1;
        wait_cyc(3);
        gpio_in[2] = 1'b0;
        wait_cyc(6);
        apb_read(32'h14, rd, err);
        check("db_glitch_in", rd, 32'h0);
        check("db_glitch_int", {31'h0, gpio_int}, 32'h0);
        gpio_in[2] = 1'b1;
        wait_cyc(6);
        gpio_in[2] = 1'b0;
        apb_read(32'h14, rd, err);
        check("db_pulse_high", rd, 32'h0000_0004);
        wait_cyc(6);
        apb_read(32'h14, rd, err);
        check("db_pulse_low", rd, 32'h0);

        // Reset in the middle of a debounce count
        gpio_in[2] = 1'b1;
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gpio_o", gpio_out, 32'h0);
        check("mid_rst_gpio_en", gpio_en, 32'h0);
        check("mid_rst_int", {31'h0, gpio_int}, 32'h0);
        check("mid_rst_prdata", prdata, 32'h0);
        check("mid_rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("mid_rst_pready", {31'h0, pready}, 32'h1);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h14;
        #1;
        check("mid_rst_in", prdata, 32'h0);
        paddr = 32'h2C;
        #1;
        check("mid_rst_dbcnt", prdata, 32'h0);
        psel = 1'b0; penable = 1'b0;
        gpio_in[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);
        apb_read(32'h00, rd, err);
        check("post_rst_out", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
